// File: rtl/reaction_timer_core.sv
// ---------------------------------------------------------------------------
// reaction_timer_core
//
// Measurement engine of the reaction timer. It debounces the player's push
// button, waits a pseudo-random delay, lights the "go" LED and counts elapsed
// milliseconds in BCD until the player presses again. It is the writer side
// of the four-digit BCD display interface.
//
// Ports
//   clk        in   1  system clock, all logic on the rising edge
//   rst_n      in   1  synchronous, active-low reset
//   btn        in   1  raw asynchronous push button, active-high
//   thousand   out  4  BCD thousands of ms
//   hund       out  4  BCD hundreds of ms
//   ten        out  4  BCD tens of ms
//   unit       out  4  BCD units of ms
//   led_go     out  1  high while the player should react (RUN)
//   too_early  out  1  high after a false start until the next round is armed
//   busy       out  1  high in ARMED or RUN
//   dbg_state  out  2  current FSM state (0 IDLE, 1 ARMED, 2 RUN)
//
// Every output comes straight from a flop; there is no combinational path
// from btn to any output.
// ---------------------------------------------------------------------------
module reaction_timer_core #(
  parameter int CLK_HZ          = 100_000_000,
  parameter int TICK_CYCLES     = 100_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int MIN_DELAY_MS    = 1000,
  parameter int RAND_BITS       = 10
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic [3:0] thousand,
  output logic [3:0] hund,
  output logic [3:0] ten,
  output logic [3:0] unit,
  output logic       led_go,
  output logic       too_early,
  output logic       busy,
  output logic [1:0] dbg_state
);

  // Counter widths. The delay register must hold MIN_DELAY_MS + 2**RAND_BITS - 1.
  localparam int PW  = $clog2(TICK_CYCLES + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int DW  = $clog2(MIN_DELAY_MS + (1 << RAND_BITS));

  // Reject parameter sets the datapath cannot represent.
  if (TICK_CYCLES < 1 || DEBOUNCE_CYCLES < 1 || MIN_DELAY_MS < 1 ||
      RAND_BITS < 1 || RAND_BITS > 16 || CLK_HZ < TICK_CYCLES) begin : g_bad_cfg
    $error("reaction_timer_core: unsupported parameter set");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Button path: 2-flop synchronizer, stability counter, rising-edge pulse.
  // -------------------------------------------------------------------------
  logic           r_sync1;
  logic           r_sync2;
  logic           r_deb;
  logic           r_deb_d;
  logic           r_press;
  logic [DBW-1:0] r_db_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_deb    <= 1'b0;
      r_deb_d  <= 1'b0;
      r_press  <= 1'b0;
      r_db_cnt <= '0;
    end else begin
      r_sync1 <= btn;
      r_sync2 <= r_sync1;
      // The debounced level follows only after the synchronized value has
      // disagreed with it for DEBOUNCE_CYCLES consecutive cycles; any cycle
      // of agreement restarts the count.
      if (r_sync2 != r_deb) begin
        if (r_db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_deb    <= r_sync2;
          r_db_cnt <= '0;
        end else begin
          r_db_cnt <= r_db_cnt + DBW'(1);
        end
      end else begin
        r_db_cnt <= '0;
      end
      r_deb_d <= r_deb;
      // Registered one-cycle pulse on the debounced rising edge only.
      r_press <= r_deb & ~r_deb_d;
    end
  end

  // -------------------------------------------------------------------------
  // 16-bit Fibonacci LFSR, taps 16,14,13,11, shifting toward bit 0.
  // Maximal length from a non-zero seed, so it never locks up at zero.
  // -------------------------------------------------------------------------
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {w_lfsr_fb, r_lfsr[15:1]};
    end
  end

  // -------------------------------------------------------------------------
  // Millisecond prescaler and BCD increment helpers.
  // -------------------------------------------------------------------------
  logic [PW-1:0] r_presc;
  logic          w_tick;

  assign w_tick = (r_presc == PW'(TICK_CYCLES - 1));

  logic [3:0] r_thou;
  logic [3:0] r_hund;
  logic [3:0] r_ten;
  logic [3:0] r_unit;
  logic [3:0] w_inc_thou;
  logic [3:0] w_inc_hund;
  logic [3:0] w_inc_ten;
  logic [3:0] w_inc_unit;
  logic       w_inc_max;

  // Ripple BCD increment: each digit wraps 9 -> 0 and carries upward.
  always_comb begin
    w_inc_thou = r_thou;
    w_inc_hund = r_hund;
    w_inc_ten  = r_ten;
    w_inc_unit = r_unit;
    if (r_unit == 4'd9) begin
      w_inc_unit = 4'd0;
      if (r_ten == 4'd9) begin
        w_inc_ten = 4'd0;
        if (r_hund == 4'd9) begin
          w_inc_hund = 4'd0;
          if (r_thou == 4'd9) begin
            w_inc_thou = 4'd0;
          end else begin
            w_inc_thou = r_thou + 4'd1;
          end
        end else begin
          w_inc_hund = r_hund + 4'd1;
        end
      end else begin
        w_inc_ten = r_ten + 4'd1;
      end
    end else begin
      w_inc_unit = r_unit + 4'd1;
    end
  end

  // The incremented value reaching 9999 ends the round as a timeout.
  assign w_inc_max = (w_inc_thou == 4'd9) && (w_inc_hund == 4'd9) &&
                     (w_inc_ten == 4'd9) && (w_inc_unit == 4'd9);

  // -------------------------------------------------------------------------
  // Round state machine with registered outputs.
  // -------------------------------------------------------------------------
  state_t        r_state;
  logic [DW-1:0] r_delay;
  logic          r_led_go;
  logic          r_too_early;
  logic          r_busy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_delay     <= '0;
      r_presc     <= '0;
      r_thou      <= 4'd0;
      r_hund      <= 4'd0;
      r_ten       <= 4'd0;
      r_unit      <= 4'd0;
      r_led_go    <= 1'b0;
      r_too_early <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      // Free-running prescaler; state entries below override it with 0 so
      // the first tick lands exactly TICK_CYCLES cycles after entry.
      if (w_tick) begin
        r_presc <= '0;
      end else begin
        r_presc <= r_presc + PW'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (r_press) begin
            r_delay     <= DW'(MIN_DELAY_MS) + DW'(r_lfsr[RAND_BITS-1:0]);
            r_thou      <= 4'd0;
            r_hund      <= 4'd0;
            r_ten       <= 4'd0;
            r_unit      <= 4'd0;
            r_too_early <= 1'b0;
            r_busy      <= 1'b1;
            r_led_go    <= 1'b0;
            r_presc     <= '0;
            r_state     <= S_ARMED;
          end
        end

        S_ARMED: begin
          // A press is checked first so it beats an expiring tick.
          if (r_press) begin
            r_thou      <= 4'd9;
            r_hund      <= 4'd9;
            r_ten       <= 4'd9;
            r_unit      <= 4'd9;
            r_too_early <= 1'b1;
            r_busy      <= 1'b0;
            r_led_go    <= 1'b0;
            r_state     <= S_IDLE;
          end else if (w_tick) begin
            r_delay <= r_delay - DW'(1);
            if (r_delay <= DW'(1)) begin
              r_led_go <= 1'b1;
              r_presc  <= '0;
              r_state  <= S_RUN;
            end
          end
        end

        S_RUN: begin
          // A tick in the same cycle as the press still counts, then the
          // value freezes.
          if (w_tick) begin
            r_thou <= w_inc_thou;
            r_hund <= w_inc_hund;
            r_ten  <= w_inc_ten;
            r_unit <= w_inc_unit;
          end
          if (r_press || (w_tick && w_inc_max)) begin
            r_busy   <= 1'b0;
            r_led_go <= 1'b0;
            r_state  <= S_IDLE;
          end
        end

        default: begin
          r_busy   <= 1'b0;
          r_led_go <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign thousand  = r_thou;
  assign hund      = r_hund;
  assign ten       = r_ten;
  assign unit      = r_unit;
  assign led_go    = r_led_go;
  assign too_early = r_too_early;
  assign busy      = r_busy;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_reaction_timer_core.sv
// ---------------------------------------------------------------------------
// Bench for reaction_timer_core with small parameters (tick = 4 cycles,
// debounce = 3 cycles, minimum delay 2 ms, 2 random bits). A behavioural
// model tracks the round in terms of milliseconds elapsed and ticks since
// state entry, and is compared with the DUT on every falling edge. Directed
// sequences add literal expectations for reset, press latency, a 37 ms round,
// bouncing, false start, BCD carry, saturation and reset during RUN.
// ---------------------------------------------------------------------------
module tb_reaction_timer_core;

  localparam int T_CYC   = 4;
  localparam int DEB_CYC = 3;
  localparam int MIN_MS  = 2;
  localparam int RBITS   = 2;

  // Clock / reset block
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn = 1'b0;
  always #5 clk = ~clk;

  logic [3:0] thousand;
  logic [3:0] hund;
  logic [3:0] ten;
  logic [3:0] unit;
  logic       led_go;
  logic       too_early;
  logic       busy;
  logic [1:0] dbg_state;

  reaction_timer_core #(
    .CLK_HZ          (100_000_000),
    .TICK_CYCLES     (T_CYC),
    .DEBOUNCE_CYCLES (DEB_CYC),
    .MIN_DELAY_MS    (MIN_MS),
    .RAND_BITS       (RBITS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn       (btn),
    .thousand  (thousand),
    .hund      (hund),
    .ten       (ten),
    .unit      (unit),
    .led_go    (led_go),
    .too_early (too_early),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model. Round state: 0 idle, 1 armed, 2 run.
  // m_ms is the elapsed-millisecond value shown on the display.
  // -------------------------------------------------------------------------
  bit          m_init = 1'b0;
  int          m_state, m_ms, m_cyc, m_ticks, m_delay, m_run;
  bit          m_early, m_s1, m_s2, m_deb, m_deb_d, m_press;
  logic [15:0] m_lfsr;

  always @(posedge clk) begin
    bit tick, new_press;
    int nxt_cyc;
    m_init = 1'b1;
    if (!rst_n) begin
      m_state = 0; m_ms = 0; m_cyc = 0; m_ticks = 0; m_delay = 0; m_run = 0;
      m_early = 0; m_s1 = 0; m_s2 = 0; m_deb = 0; m_deb_d = 0; m_press = 0;
      m_lfsr = 16'hACE1;
    end else begin
      // ms ticks fall every T_CYC cycles counted from the last state entry
      tick    = ((m_cyc % T_CYC) == T_CYC - 1);
      nxt_cyc = m_cyc + 1;
      case (m_state)
        0: if (m_press) begin
             m_delay = MIN_MS + int'(m_lfsr % (1 << RBITS));
             m_ms = 0; m_early = 0; m_ticks = 0; m_state = 1; nxt_cyc = 0;
           end
        1: if (m_press) begin
             m_ms = 9999; m_early = 1; m_state = 0;
           end else if (tick) begin
             m_ticks++;
             if (m_ticks == m_delay) begin m_state = 2; nxt_cyc = 0; end
           end
        default: begin
          if (tick) m_ms++;
          if (m_press || m_ms == 9999) m_state = 0;
        end
      endcase
      m_cyc = nxt_cyc;
      // button: level accepted after DEB_CYC consecutive disagreeing cycles
      new_press = m_deb && !m_deb_d;
      m_deb_d   = m_deb;
      if (m_s2 != m_deb) begin
        m_run++;
        if (m_run == DEB_CYC) begin m_deb = m_s2; m_run = 0; end
      end else begin
        m_run = 0;
      end
      m_s2 = m_s1;
      m_s1 = btn;
      m_press = new_press;
      m_lfsr = {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};
    end
  end

  // Scoreboard compare on every falling edge once the model has started.
  always @(negedge clk) begin
    logic [15:0] e_dig;
    logic [21:0] e_all, g_all;
    if (m_init) begin
      e_dig = {4'(m_ms / 1000), 4'((m_ms / 100) % 10), 4'((m_ms / 10) % 10), 4'(m_ms % 10)};
      e_all = {e_dig, (m_state == 2), m_early, (m_state != 0), 2'(m_state), 1'b0};
      g_all = {thousand, hund, ten, unit, led_go, too_early, busy, dbg_state, 1'b0};
      total++;
      if (g_all !== e_all) begin
        bad++;
        $display("FAIL model_cmp got dig=%h led=%b early=%b busy=%b st=%0d exp dig=%h led=%b early=%b busy=%b st=%0d at %0t",
                 g_all[21:6], g_all[5], g_all[4], g_all[3], g_all[2:1],
                 e_all[21:6], e_all[5], e_all[4], e_all[3], e_all[2:1], $time);
      end
    end
  end

  bit led_seen = 1'b0;
  always @(negedge clk) if (led_go) led_seen = 1'b1;

  // -------------------------------------------------------------------------
  // Driver tasks
  // -------------------------------------------------------------------------
  task automatic press_hold(input int hi, input int lo);
    btn = 1'b1;
    repeat (hi) @(negedge clk);
    btn = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  task automatic wait_led(input int budget, input string name, output int n);
    n = 0;
    while (!led_go && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, int'(led_go), 1);
  endtask

  function automatic int digits();
    return int'({thousand, hund, ten, unit});
  endfunction

  // -------------------------------------------------------------------------
  // Directed sequence
  // -------------------------------------------------------------------------
  initial begin
    int n;
    // reset held for 5 cycles with btn toggling
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("rst_outputs", int'({thousand, hund, ten, unit, led_go, too_early, busy}), 0);
      btn = ~btn;
    end
    btn = 1'b0;
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // press latency: busy rises exactly 7 cycles after btn
    btn = 1'b1;
    repeat (6) @(negedge clk);
    check("busy_at_6", int'(busy), 0);
    @(negedge clk);
    check("busy_at_7", int'(busy), 1);
    btn = 1'b0;

    // normal round: wait 2..5 ms, then 37 ticks in RUN
    wait_led(40, "led_go_rise", n);
    check("armed_wait_8_20", int'(n >= 8 && n <= 20), 1);
    repeat (142) @(negedge clk);
    press_hold(10, 0);
    check("round_digits", digits(), 16'h0037);
    check("round_led", int'(led_go), 0);
    check("round_busy", int'(busy), 0);
    check("round_early", int'(too_early), 0);
    repeat (10) @(negedge clk);

    // bounce: three 2-cycle pulses must be ignored
    repeat (3) press_hold(2, 4);
    repeat (10) @(negedge clk);
    check("bounce_busy", int'(busy), 0);
    check("bounce_state", int'(dbg_state), 0);
    check("bounce_digits", digits(), 16'h0037);

    // false start: second press 6 cycles into ARMED
    led_seen = 1'b0;
    press_hold(3, 3);
    press_hold(5, 8);
    check("fs_digits", digits(), 16'h9999);
    check("fs_early", int'(too_early), 1);
    check("fs_no_led", int'(led_seen), 0);
    check("fs_busy", int'(busy), 0);
    repeat (10) @(negedge clk);

    // next press clears too_early and the digits
    press_hold(8, 0);
    check("rearm_busy", int'(busy), 1);
    check("rearm_early", int'(too_early), 0);
    check("rearm_digits", digits(), 16'h0000);

    // carry 0999 -> 1000, then run to saturation
    wait_led(40, "led_go_rise2", n);
    n = 0;
    while (digits() != 16'h0999 && n < 6000) begin @(negedge clk); n++; end
    check("reach_0999", digits(), 16'h0999);
    n = 0;
    while (digits() == 16'h0999 && n < 10) begin @(negedge clk); n++; end
    check("carry_1000", digits(), 16'h1000);
    n = 0;
    while (busy && n < 50000) begin @(negedge clk); n++; end
    check("sat_busy", int'(busy), 0);
    check("sat_digits", digits(), 16'h9999);
    check("sat_early", int'(too_early), 0);
    check("sat_led", int'(led_go), 0);
    check("sat_state", int'(dbg_state), 0);
    repeat (10) @(negedge clk);

    // reset for one cycle during RUN
    press_hold(8, 0);
    wait_led(40, "led_go_rise3", n);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_outputs", int'({thousand, hund, ten, unit, led_go, too_early, busy}), 0);
    check("midrst_state", int'(dbg_state), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound so the run always ends.
  initial begin
    #1_000_000;
    bad++;
    $display("FAIL watchdog time limit reached at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reaction_timer_core.md
# reaction_timer_core

Measurement engine of the reaction timer. It produces the four BCD digits (thousand, hund, ten, unit) consumed by the 7-segment display path. It debounces the player's push-button, waits a pseudo-random delay, lights the "go" LED, and counts elapsed milliseconds in BCD until the player presses again. It sits between the raw board button and the display driver and is the writer side of the four-digit BCD interface.

## Interface
- CLK_HZ, 100_000_000: clock frequency, documentation only.
- TICK_CYCLES, 100_000: clock cycles per 1 ms tick.
- DEBOUNCE_CYCLES, 1_000_000: cycles the synchronized button must stay stable before the debounced level changes.
- MIN_DELAY_MS, 1000: minimum wait before "go".
- RAND_BITS, 10: number of LFSR bits added to MIN_DELAY_MS to form the random wait.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- btn  in  1  raw asynchronous push-button, active-high.
- thousand  out  4  BCD thousands of ms.
- hund  out  4  BCD hundreds of ms.
- ten  out  4  BCD tens of ms.
- unit  out  4  BCD units of ms.
- led_go  out  1  high while the player should react (RUN state).
- too_early  out  1  high after a false start, until the next round is armed.
- busy  out  1  high in ARMED or RUN.

## Operation
- Button path:
  - 2-flop synchronizer.
  - Stability counter: the debounced level takes the synchronized value once the two have differed for DEBOUNCE_CYCLES consecutive cycles. Any return to equality clears the counter.
  - `press` is a 1-cycle pulse on the debounced rising edge. Release generates no event.
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11, seed 16'hACE1.
  - Advances every cycle, including during reset deassertion. It never reaches zero.
- ms tick: a prescaler counts 0..TICK_CYCLES-1 and pulses `tick` at TICK_CYCLES-1. It is forced to 0 on entry to ARMED and on entry to RUN, so the first tick comes exactly TICK_CYCLES cycles after entry.
- State machine:
  - IDLE: digits hold the last result; led_go=0.
    - On press: load delay = MIN_DELAY_MS + lfsr[RAND_BITS-1:0], clear digits to 0000, clear too_early, go to ARMED.
  - ARMED: busy=1; decrement delay on each tick.
    - Press before the delay expires (false start): digits=9999, too_early=1, go to IDLE.
    - Delay reaches 0 on a tick: go to RUN with led_go=1.
    - If press and the expiring tick fall in the same cycle, press wins (false start).
  - RUN: led_go=1, busy=1.
    - Each tick increments the 4-digit BCD counter. Each digit wraps 9→0 with carry.
    - On press: freeze digits, go to IDLE.
    - Reaching 9999: saturate, go to IDLE (timeout), too_early stays 0.
    - If press and tick fall in the same cycle, the tick increment is applied first, then the value is frozen.
- Only BCD values 0-9 ever appear on any digit output.
- Reset mid-operation: every register takes its reset value on the next edge. The round is abandoned and the LFSR is reseeded.

## Timing
- Reset values: thousand=hund=ten=unit=0, led_go=0, too_early=0, busy=0, state IDLE, debounced level 0, prescaler 0, LFSR 16'hACE1.
- btn rising edge to `press`:
  - 2 cycles of synchronizer, plus
  - DEBOUNCE_CYCLES of stability, plus
  - 1 cycle of edge detect.
- press to state change: 1 cycle. busy, led_go and the digits are registered and update together with the state.
- In RUN, a measured value of N ms means N ticks occurred between RUN entry and the press being accepted.
- All outputs are registered. There is no combinational path from btn to any output.

## Test plan
Test parameters: TICK_CYCLES=4, DEBOUNCE_CYCLES=3, MIN_DELAY_MS=2, RAND_BITS=2.
- Reset: hold rst_n=0 for 5 cycles with btn toggling. Expect all outputs 0 and busy=0. After release, one clean press gives busy=1 exactly 7 cycles after btn rises.
- Bounce: btn pulses high for 2 cycles three times, then stays low. Expect no press, state stays IDLE, digits unchanged.
- Normal round:
  - Press, then wait for led_go=1. The wait must be 2-5 ms, i.e. 8-20 cycles after ARMED entry.
  - Press again after 37 ticks in RUN. Expect digits 0,0,3,7, led_go=0, busy=0, too_early=0.
- False start: press, then press again while in ARMED. Expect digits 9,9,9,9, too_early=1, led_go never high. The next press clears too_early and digits read 0000.
- Carry and saturation:
  - Preload or run to 0999 and apply one tick. Expect 1,0,0,0.
  - Run with no press until 9999. Expect saturation at 9,9,9,9, return to IDLE, too_early=0.
- Reset mid-RUN: assert rst_n=0 for 1 cycle while led_go=1. Expect all outputs 0 on the next edge and state IDLE.
